// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multicycle LEGv8 main control.
// LEGV8_CBNZ_EN (optional) enables CBNZ decoding in legv8_mc_control.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_CBZ     = 4'd8,
    S_JUMP    = 4'd9,
    S_CBNZ    = 4'd10,
    S_ERROR   = 4'd15
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [7:0] OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ_PFX = 8'b10110101;
  localparam logic [5:0] OP_B_PFX    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/legv8_mem_wait_timer.sv
// Bounded-wait counter for memory handshake states.
// Flags expiry when the count reaches MEM_TIMEOUT with ready still low.
module legv8_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || ready)
      cnt <= '0;
    else if (busy)
      cnt <= cnt + 1'b1;
  end

  assign expire = busy && !ready &&
                  (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/legv8_mc_control.sv
// Multicycle LEGv8 main control FSM (ALUop producer).
// Define LEGV8_CBNZ_EN to decode CBNZ; otherwise it is illegal.
module legv8_mc_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [1:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic [3:0]  State,
  output logic        Error
);

  state_t state, nxt;
  logic   busy, expire;
  logic   is_ldur, is_stur, is_r;
  logic   is_cbz, is_cbnz, is_b;

  assign is_ldur = (Opcode == OP_LDUR);
  assign is_stur = (Opcode == OP_STUR);
  assign is_r    = (Opcode == OP_ADD) ||
                   (Opcode == OP_SUB) ||
                   (Opcode == OP_AND) ||
                   (Opcode == OP_ORR);
  assign is_cbz  = (Opcode[10:3] == OP_CBZ_PFX);
  assign is_b    = (Opcode[10:5] == OP_B_PFX);
`ifdef LEGV8_CBNZ_EN
  assign is_cbnz = (Opcode[10:3] == OP_CBNZ_PFX);
`else
  assign is_cbnz = 1'b0;
`endif

  assign busy  = (state == S_FETCH) ||
                 (state == S_MEMRD) ||
                 (state == S_MEMWR);
  assign State = state;

  legv8_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk   (CLK),
    .rst_n (Reset_L),
    .clr   (state != nxt),
    .busy  (busy),
    .ready (MemReady),
    .expire(expire)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= S_FETCH;
    else          state <= nxt;
  end

  always_comb begin
    nxt         = state;
    ALUop       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    Reg2Loc     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    Error       = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady)    nxt = S_DECODE;
        else if (expire) nxt = S_ERROR;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        Reg2Loc = is_stur | is_cbz | is_cbnz;
        unique case (1'b1)
          is_ldur,
          is_stur: nxt = S_MEMADDR;
          is_r:    nxt = S_EXEC_R;
          is_cbz:  nxt = S_CBZ;
          is_cbnz: nxt = S_CBNZ;
          is_b:    nxt = S_JUMP;
          default: nxt = S_ERROR;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        nxt = is_ldur ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)    nxt = S_MEMWB;
        else if (expire) nxt = S_ERROR;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (MemReady)    nxt = S_FETCH;
        else if (expire) nxt = S_ERROR;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_RTYPE;
        nxt = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        nxt = S_FETCH;
      end
      S_CBZ: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOP_PASSB;
        Reg2Loc     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        nxt = S_FETCH;
      end
      S_CBNZ: begin
        ALUSrcA  = 1'b1;
        ALUop    = ALUOP_PASSB;
        Reg2Loc  = 1'b1;
        PCWrite  = !Zero;
        PCSource = 1'b1;
        nxt = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        nxt = S_FETCH;
      end
      S_ERROR: Error = 1'b1;
      default: nxt = S_ERROR;
    endcase
    // outputs are forced quiet for the whole reset window
    if (!Reset_L)
      {ALUop, ALUSrcA, ALUSrcB, Reg2Loc,
       MemRead, MemWrite, IorD, IRWrite,
       MemtoReg, RegWrite, PCWrite,
       PCWriteCond, PCSource, Error} = '0;
  end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Directed table-driven bench for legv8_mc_control.
// Build with +define+LEGV8_CBNZ_EN to cover the CBNZ variant.
module tb_legv8_mc_control;

  logic        CLK = 1'b0;
  logic        Reset_L, Zero, MemReady;
  logic [10:0] Opcode;
  logic [1:0]  ALUop, ALUSrcB;
  logic        ALUSrcA, Reg2Loc, MemRead, MemWrite;
  logic        IorD, IRWrite, MemtoReg, RegWrite;
  logic        PCWrite, PCWriteCond, PCSource, Error;
  logic [3:0]  State;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  legv8_mc_control dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .Reg2Loc(Reg2Loc),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .State(State),
    .Error(Error)
  );

  logic [19:0] act;
  assign act = {State, ALUop, ALUSrcA, ALUSrcB,
                Reg2Loc, MemRead, MemWrite, IorD,
                IRWrite, MemtoReg, RegWrite, PCWrite,
                PCWriteCond, PCSource, Error};

  // f = {r2l,mr,mw,iord,irw,m2r,rw,pcw,pcwc,pcs}
  function automatic logic [19:0] ev(
    input logic [3:0] st, input logic [1:0] aop,
    input logic sa, input logic [1:0] sb,
    input logic [9:0] f, input logic err);
    return {st, aop, sa, sb, f, err};
  endfunction

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100000;
  localparam logic [10:0] CBNZ = 11'b10110101000;
  localparam logic [10:0] BR   = 11'b00010100111;
  localparam logic [10:0] BAD  = 11'b11111111111;

  logic [19:0] e_rst, e_f1, e_f0, e_d0, e_d1;
  logic [19:0] e_ma, e_mrd, e_mwb, e_mwr, e_ex;
  logic [19:0] e_rwb, e_cbz, e_j, e_err, e_cbnz;

  typedef struct {
    logic [10:0] op;
    logic        rdy;
    logic        z;
    logic [19:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [10:0] op,
                     input logic rdy, input logic z,
                     input logic [19:0] exp,
                     input string nm);
    Opcode = op; MemReady = rdy; Zero = z;
    @(negedge CLK);
    chk(nm, exp);
    @(posedge CLK); #1;
  endtask

  task automatic add(input logic [10:0] op,
                     input logic rdy, input logic z,
                     input logic [19:0] exp,
                     input string nm);
    vec_t v;
    v.op = op; v.rdy = rdy; v.z = z;
    v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input string nm);
    Reset_L = 1'b0;
    #1 chk(nm, e_rst);
    @(posedge CLK); #1;
    Reset_L = 1'b1;
  endtask

  task automatic r_instr(input logic [10:0] op,
                         input string nm);
    add(op, 1, 0, e_f1,  {nm, "_f"});
    add(op, 1, 0, e_d0,  {nm, "_d"});
    add(op, 1, 0, e_ex,  {nm, "_ex"});
    add(op, 1, 0, e_rwb, {nm, "_wb"});
  endtask

  initial begin
    e_rst  = ev(0, 2'b00, 0, 2'b00, 10'b0000000000, 0);
    e_f1   = ev(0, 2'b00, 0, 2'b01, 10'b0100100100, 0);
    e_f0   = ev(0, 2'b00, 0, 2'b01, 10'b0100000000, 0);
    e_d0   = ev(1, 2'b00, 0, 2'b11, 10'b0000000000, 0);
    e_d1   = ev(1, 2'b00, 0, 2'b11, 10'b1000000000, 0);
    e_ma   = ev(2, 2'b00, 1, 2'b10, 10'b0000000000, 0);
    e_mrd  = ev(3, 2'b00, 0, 2'b00, 10'b0101000000, 0);
    e_mwb  = ev(4, 2'b00, 0, 2'b00, 10'b0000011000, 0);
    e_mwr  = ev(5, 2'b00, 0, 2'b00, 10'b1011000000, 0);
    e_ex   = ev(6, 2'b10, 1, 2'b00, 10'b0000000000, 0);
    e_rwb  = ev(7, 2'b00, 0, 2'b00, 10'b0000001000, 0);
    e_cbz  = ev(8, 2'b01, 1, 2'b00, 10'b1000000011, 0);
    e_j    = ev(9, 2'b00, 0, 2'b00, 10'b0000000101, 0);
    e_cbnz = ev(10, 2'b01, 1, 2'b00, 10'b1000000101, 0);
    e_err  = ev(15, 2'b00, 0, 2'b00, 10'b0000000000, 1);

    r_instr(ADD, "add");
    add(LDUR, 1, 0, e_f1,  "ld_f");
    add(LDUR, 1, 0, e_d0,  "ld_d");
    add(LDUR, 1, 0, e_ma,  "ld_ma");
    add(LDUR, 0, 0, e_mrd, "ld_rd_w0");
    add(LDUR, 0, 0, e_mrd, "ld_rd_w1");
    add(LDUR, 0, 0, e_mrd, "ld_rd_w2");
    add(LDUR, 1, 0, e_mrd, "ld_rd_ok");
    add(LDUR, 1, 0, e_mwb, "ld_wb");
    add(STUR, 1, 0, e_f1,  "st_f");
    add(STUR, 1, 0, e_d1,  "st_d");
    add(STUR, 1, 0, e_ma,  "st_ma");
    add(STUR, 1, 0, e_mwr, "st_wr");
    add(CBZ,  0, 1, e_f0,  "cbz_fwait");
    add(CBZ,  1, 1, e_f1,  "cbz_f");
    add(CBZ,  1, 1, e_d1,  "cbz_d");
    add(CBZ,  1, 1, e_cbz, "cbz_x");
    add(BR,   1, 0, e_f1,  "b_f");
    add(BR,   1, 0, e_d0,  "b_d");
    add(BR,   1, 0, e_j,   "b_j");
    r_instr(SUB,  "sub");
    r_instr(ANDI, "and");
    r_instr(ORR,  "orr");
    add(ADD,  1, 0, e_f1,  "tail_f");

    Reset_L = 1'b0; Opcode = '0;
    Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("reset", e_rst);
    Reset_L = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].op, tbl[i].rdy, tbl[i].z,
          tbl[i].exp, tbl[i].nm);

    // reset lands in the middle of EXEC_R
    do_reset("rst_pre");
    cyc(ADD, 1, 0, e_f1, "mid_f");
    cyc(ADD, 1, 0, e_d0, "mid_d");
    #1 chk("mid_ex", e_ex);
    do_reset("mid_rst");

    // illegal opcode, then sticky ERROR
    cyc(BAD, 1, 0, e_f1, "ill_f");
    cyc(BAD, 1, 0, e_d0, "ill_d");
    cyc(BAD, 1, 0, e_err, "ill_err");
    cyc(ADD, 1, 0, e_err, "ill_stk0");
    cyc(LDUR, 0, 1, e_err, "ill_stk1");
    do_reset("ill_rst");

    // store timeout: count runs 0..15, then ERROR
    cyc(STUR, 1, 0, e_f1, "to_f");
    cyc(STUR, 1, 0, e_d1, "to_d");
    cyc(STUR, 1, 0, e_ma, "to_ma");
    for (int k = 0; k < 16; k++)
      cyc(STUR, 0, 0, e_mwr, "to_wait");
    cyc(STUR, 1, 0, e_err, "to_err");
    do_reset("to_rst");

    // ready arrives exactly at the expiry count
    cyc(STUR, 1, 0, e_f1, "rs_f");
    cyc(STUR, 1, 0, e_d1, "rs_d");
    cyc(STUR, 1, 0, e_ma, "rs_ma");
    for (int k = 0; k < 15; k++)
      cyc(STUR, 0, 0, e_mwr, "rs_wait");
    cyc(STUR, 1, 0, e_mwr, "rs_last");
    cyc(ADD,  1, 0, e_f1, "rs_fetch");
    cyc(ADD,  1, 0, e_d0, "rs_d2");
    do_reset("rs_rst");

`ifdef LEGV8_CBNZ_EN
    cyc(CBNZ, 1, 0, e_f1,   "cbnz_f");
    cyc(CBNZ, 1, 0, e_d1,   "cbnz_d");
    cyc(CBNZ, 1, 0, e_cbnz, "cbnz_x");
    cyc(ADD,  1, 0, e_f1,   "cbnz_next");
`else
    cyc(CBNZ, 1, 0, e_f1,  "cbnz_f");
    cyc(CBNZ, 1, 0, e_d0,  "cbnz_d");
    cyc(CBNZ, 1, 0, e_err, "cbnz_ill");
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
